// File: rtl/breakout_game_ctrl.sv
// breakout_game_ctrl
//   Game-flow controller for the Breakout display path. It turns graph-unit
//   event pulses (paddle/brick hit, miss) and the per-frame tick into the
//   graphics freeze control, the ball count, a packed BCD score, the level
//   number and a brick-field reload pulse. All outputs are registered.
//
// Ports
//   clk, reset      system clock, asynchronous active-high reset
//   frame_tick      one-clk pulse per video frame
//   start           start/launch key (level); a rising edge is one launch
//   paddle_hit      ball hit paddle (no effect on game flow)
//   brick_hit       ball destroyed one brick
//   miss            ball left the bottom edge
//   state           0 NEWGAME, 1 PLAY, 2 NEWBALL, 3 LEVELUP, 4 OVER
//   gra_still       1 = graph unit freezes the ball
//   balls_left      remaining balls
//   score           packed BCD, digit 0 in the LSBs, saturates at all-9s
//   level           current level, 0-based, saturates at MAX_LEVEL
//   bricks_reload   one-clk pulse: restore the brick field
//   game_over       high in OVER
//   hiscore         (only with BREAKOUT_HISCORE_EN) best final score
//
// Build option: define BREAKOUT_HISCORE_EN to add the hiscore output.

module breakout_game_ctrl #(
    parameter int unsigned LIVES        = 3,
    parameter int unsigned SCORE_DIGITS = 4,
    parameter int unsigned BRICKS       = 40,
    parameter int unsigned PAUSE_FRAMES = 60,
    parameter int unsigned MAX_LEVEL    = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      frame_tick,
    input  logic                      start,
    input  logic                      paddle_hit,
    input  logic                      brick_hit,
    input  logic                      miss,
    output logic [2:0]                state,
    output logic                      gra_still,
    output logic [3:0]                balls_left,
    output logic [4*SCORE_DIGITS-1:0] score,
    output logic [2:0]                level,
    output logic                      bricks_reload,
    output logic                      game_over
`ifdef BREAKOUT_HISCORE_EN
    ,
    output logic [4*SCORE_DIGITS-1:0] hiscore
`endif
);

    localparam int unsigned SW = 4 * SCORE_DIGITS;
    // Counter may briefly hold BRICKS+1 if a hit lands while a deferred
    // level-complete is still pending.
    localparam int unsigned CW = $clog2(BRICKS + 2);
    localparam int unsigned TW = $clog2(PAUSE_FRAMES + 1);

    typedef enum logic [2:0] {
        S_NEWGAME = 3'd0,
        S_PLAY    = 3'd1,
        S_NEWBALL = 3'd2,
        S_LEVELUP = 3'd3,
        S_OVER    = 3'd4
    } state_t;

    state_t          st, st_nx;
    logic            start_q;
    logic            launch;
    logic [CW-1:0]   brick_cnt, cnt_nx, cnt_inc;
    logic [TW-1:0]   timer, timer_nx;
    logic [3:0]      balls_nx;
    logic [SW-1:0]   score_nx;
    logic [2:0]      level_nx;
    logic            reload_nx;
    logic            unused_paddle;

    // paddle_hit only feeds sound/debug elsewhere.
    assign unused_paddle = paddle_hit;

    assign launch  = start & ~start_q;
    assign cnt_inc = brick_cnt + CW'(brick_hit);
    assign state   = st;

    // Ripple BCD add of a small increment; carry out of the top digit pins
    // the score at all-9s instead of wrapping.
    function automatic logic [SW-1:0] bcd_add_sat(input logic [SW-1:0] a,
                                                  input logic [3:0]    inc);
        logic [4:0]    carry;
        logic [4:0]    sum;
        logic [SW-1:0] r;
        carry = {1'b0, inc};
        r     = '0;
        for (int unsigned i = 0; i < SCORE_DIGITS; i++) begin
            sum = {1'b0, a[4*i +: 4]} + carry;
            if (sum > 5'd9) begin
                r[4*i +: 4] = 4'(sum - 5'd10);
                carry       = 5'd1;
            end else begin
                r[4*i +: 4] = sum[3:0];
                carry       = 5'd0;
            end
        end
        if (carry != 5'd0)
            r = {SCORE_DIGITS{4'h9}};
        return r;
    endfunction

    always_comb begin
        st_nx     = st;
        cnt_nx    = brick_cnt;
        timer_nx  = timer;
        balls_nx  = balls_left;
        score_nx  = score;
        level_nx  = level;
        reload_nx = 1'b0;
        case (st)
            S_NEWGAME: begin
                if (launch) begin
                    balls_nx  = 4'(LIVES);
                    score_nx  = '0;
                    level_nx  = '0;
                    cnt_nx    = '0;
                    reload_nx = 1'b1;
                    st_nx     = S_PLAY;
                end
            end
            S_PLAY: begin
                if (brick_hit) begin
                    score_nx = bcd_add_sat(score, {1'b0, level} + 4'd1);
                    cnt_nx   = cnt_inc;
                end
                // A miss takes priority over level completion; the counter is
                // left at its full value so the check fires on return to PLAY.
                if (miss) begin
                    balls_nx = balls_left - 4'd1;
                    timer_nx = '0;
                    st_nx    = (balls_left == 4'd1) ? S_OVER : S_NEWBALL;
                end else if (cnt_inc >= CW'(BRICKS)) begin
                    cnt_nx   = '0;
                    timer_nx = '0;
                    st_nx    = S_LEVELUP;
                end
            end
            S_NEWBALL, S_LEVELUP: begin
                if (frame_tick)
                    timer_nx = timer + TW'(1);
                if (launch || (frame_tick && timer == TW'(PAUSE_FRAMES - 1))) begin
                    st_nx = S_PLAY;
                    if (st == S_LEVELUP) begin
                        level_nx  = (level < 3'(MAX_LEVEL)) ? level + 3'd1 : level;
                        reload_nx = 1'b1;
                    end
                end
            end
            S_OVER: begin
                if (launch)
                    st_nx = S_NEWGAME;
            end
            default: st_nx = S_NEWGAME;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st            <= S_NEWGAME;
            start_q       <= 1'b0;
            brick_cnt     <= '0;
            timer         <= '0;
            balls_left    <= 4'(LIVES);
            score         <= '0;
            level         <= '0;
            bricks_reload <= 1'b0;
            gra_still     <= 1'b1;
            game_over     <= 1'b0;
        end else begin
            st            <= st_nx;
            start_q       <= start;
            brick_cnt     <= cnt_nx;
            timer         <= timer_nx;
            balls_left    <= balls_nx;
            score         <= score_nx;
            level         <= level_nx;
            bricks_reload <= reload_nx;
            gra_still     <= (st_nx != S_PLAY);
            game_over     <= (st_nx == S_OVER);
        end
    end

`ifdef BREAKOUT_HISCORE_EN
    // With every digit in 0..9, packed BCD orders the same as plain binary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            hiscore <= '0;
        else if (st_nx == S_OVER && st != S_OVER && score_nx > hiscore)
            hiscore <= score_nx;
    end
`endif

endmodule

// File: tb/tb_breakout_game_ctrl.sv
module tb_breakout_game_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, frame_tick, start, paddle_hit, brick_hit, miss;
    logic [2:0]  state;
    logic        gra_still;
    logic [3:0]  balls_left;
    logic [15:0] score;
    logic [2:0]  level;
    logic        bricks_reload, game_over;
`ifdef BREAKOUT_HISCORE_EN
    logic [15:0] hiscore;
    logic [7:0]  s2_hiscore;
`endif

    logic        s2_start, s2_hit;
    logic [2:0]  s2_state;
    logic        s2_still;
    logic [3:0]  s2_balls;
    logic [7:0]  s2_score;
    logic [2:0]  s2_level;
    logic        s2_reload, s2_over;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    breakout_game_ctrl #(
        .LIVES(3), .SCORE_DIGITS(4), .BRICKS(4), .PAUSE_FRAMES(60), .MAX_LEVEL(7)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
        .paddle_hit(paddle_hit), .brick_hit(brick_hit), .miss(miss),
        .state(state), .gra_still(gra_still), .balls_left(balls_left),
        .score(score), .level(level), .bricks_reload(bricks_reload),
        .game_over(game_over)
`ifdef BREAKOUT_HISCORE_EN
        , .hiscore(hiscore)
`endif
    );

    // Two-digit instance with a large brick target for score saturation.
    breakout_game_ctrl #(
        .LIVES(2), .SCORE_DIGITS(2), .BRICKS(200), .PAUSE_FRAMES(2), .MAX_LEVEL(7)
    ) dut2 (
        .clk(clk), .reset(reset), .frame_tick(1'b0), .start(s2_start),
        .paddle_hit(1'b0), .brick_hit(s2_hit), .miss(1'b0),
        .state(s2_state), .gra_still(s2_still), .balls_left(s2_balls),
        .score(s2_score), .level(s2_level), .bricks_reload(s2_reload),
        .game_over(s2_over)
`ifdef BREAKOUT_HISCORE_EN
        , .hiscore(s2_hiscore)
`endif
    );

    typedef struct {
        logic        st, bh, ms, ft, ph;
        logic [2:0]  e_state;
        logic [3:0]  e_balls;
        logic [15:0] e_score;
        logic [2:0]  e_level;
        logic        e_reload, e_still, e_over;
    } vec_t;

    vec_t vt[26];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else
            n_pass++;
    endtask

    task automatic check_all(input string tag, input logic [2:0] es, input logic [3:0] eb,
                             input logic [15:0] esc, input logic [2:0] el,
                             input logic er, input logic estill, input logic eo);
        chk($sformatf("%s.state", tag), 32'(state), 32'(es));
        chk($sformatf("%s.balls_left", tag), 32'(balls_left), 32'(eb));
        chk($sformatf("%s.score", tag), 32'(score), 32'(esc));
        chk($sformatf("%s.level", tag), 32'(level), 32'(el));
        chk($sformatf("%s.bricks_reload", tag), 32'(bricks_reload), 32'(er));
        chk($sformatf("%s.gra_still", tag), 32'(gra_still), 32'(estill));
        chk($sformatf("%s.game_over", tag), 32'(game_over), 32'(eo));
    endtask

    task automatic cycle(input logic st, input logic bh, input logic ms,
                         input logic ft, input logic ph);
        @(negedge clk);
        start = st; brick_hit = bh; miss = ms; frame_tick = ft; paddle_hit = ph;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_row(input int unsigned i);
        cycle(vt[i].st, vt[i].bh, vt[i].ms, vt[i].ft, vt[i].ph);
        check_all($sformatf("row%0d", i), vt[i].e_state, vt[i].e_balls, vt[i].e_score,
                  vt[i].e_level, vt[i].e_reload, vt[i].e_still, vt[i].e_over);
    endtask

    function automatic logic [7:0] to_bcd2(input int unsigned v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            st bh ms ft ph  state balls score     lvl rld still over
        vt[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 3'd0, 4'd3, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0};
        vt[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 3'd1, 4'd3, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0};
        vt[2]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 3'd1, 4'd3, 16'h0001, 3'd0, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{1'b0,1'b1,1'b0,1'b0,1'b1, 3'd1, 4'd3, 16'h0002, 3'd0, 1'b0, 1'b0, 1'b0};
        vt[4]  = '{1'b0,1'b0,1'b0,1'b1,1'b1, 3'd1, 4'd3, 16'h0002, 3'd0, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 3'd1, 4'd3, 16'h0003, 3'd0, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 3'd3, 4'd3, 16'h0004, 3'd0, 1'b0, 1'b1, 1'b0};
        vt[7]  = '{1'b0,1'b1,1'b1,1'b0,1'b0, 3'd3, 4'd3, 16'h0004, 3'd0, 1'b0, 1'b1, 1'b0};
        // after the timed level-up: level 1, score 4, three balls
        vt[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 3'd1, 4'd3, 16'h0004, 3'd1, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 3'd2, 4'd2, 16'h0004, 3'd1, 1'b0, 1'b1, 1'b0};
        vt[10] = '{1'b0,1'b1,1'b1,1'b1,1'b0, 3'd2, 4'd2, 16'h0004, 3'd1, 1'b0, 1'b1, 1'b0};
        vt[11] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 3'd1, 4'd2, 16'h0004, 3'd1, 1'b0, 1'b0, 1'b0};
        vt[12] = '{1'b0,1'b1,1'b0,1'b0,1'b0, 3'd1, 4'd2, 16'h0006, 3'd1, 1'b0, 1'b0, 1'b0};
        vt[13] = '{1'b0,1'b1,1'b0,1'b0,1'b0, 3'd1, 4'd2, 16'h0008, 3'd1, 1'b0, 1'b0, 1'b0};
        vt[14] = '{1'b0,1'b1,1'b0,1'b0,1'b0, 3'd1, 4'd2, 16'h0010, 3'd1, 1'b0, 1'b0, 1'b0};
        vt[15] = '{1'b0,1'b1,1'b1,1'b0,1'b0, 3'd2, 4'd1, 16'h0012, 3'd1, 1'b0, 1'b1, 1'b0};
        vt[16] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 3'd1, 4'd1, 16'h0012, 3'd1, 1'b0, 1'b0, 1'b0};
        vt[17] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 3'd3, 4'd1, 16'h0012, 3'd1, 1'b0, 1'b1, 1'b0};
        vt[18] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 3'd1, 4'd1, 16'h0012, 3'd2, 1'b1, 1'b0, 1'b0};
        vt[19] = '{1'b0,1'b1,1'b0,1'b0,1'b0, 3'd1, 4'd1, 16'h0015, 3'd2, 1'b0, 1'b0, 1'b0};
        vt[20] = '{1'b0,1'b0,1'b1,1'b0,1'b0, 3'd4, 4'd0, 16'h0015, 3'd2, 1'b0, 1'b1, 1'b1};
        vt[21] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 3'd4, 4'd0, 16'h0015, 3'd2, 1'b0, 1'b1, 1'b1};
        vt[22] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 3'd0, 4'd0, 16'h0015, 3'd2, 1'b0, 1'b1, 1'b0};
        vt[23] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 3'd0, 4'd0, 16'h0015, 3'd2, 1'b0, 1'b1, 1'b0};
        vt[24] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 3'd1, 4'd3, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0};
        vt[25] = '{1'b0,1'b1,1'b0,1'b0,1'b0, 3'd1, 4'd3, 16'h0001, 3'd0, 1'b0, 1'b0, 1'b0};

        reset = 1'b1; start = 1'b0; brick_hit = 1'b0; miss = 1'b0;
        frame_tick = 1'b0; paddle_hit = 1'b0; s2_start = 1'b0; s2_hit = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 3'd0, 4'd3, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        for (int unsigned i = 0; i < 8; i++)
            apply_row(i);

        // LEVELUP holds for 60 frames with no key, exits on the 60th tick.
        for (int unsigned f = 0; f < 59; f++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            if (f == 0 || f == 58)
                check_all($sformatf("pause_f%0d", f + 1), 3'd3, 4'd3, 16'h0004, 3'd0,
                          1'b0, 1'b1, 1'b0);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_all("pause_exit", 3'd1, 4'd3, 16'h0004, 3'd1, 1'b1, 1'b0, 1'b0);

        for (int unsigned i = 8; i < 26; i++)
            apply_row(i);

`ifdef BREAKOUT_HISCORE_EN
        chk("hiscore_kept", 32'(hiscore), 32'h0015);
`endif

        // asynchronous reset mid-PLAY takes effect before any clock edge
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_all("async_reset", 3'd0, 4'd3, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0);
`ifdef BREAKOUT_HISCORE_EN
        chk("hiscore_reset", 32'(hiscore), 32'h0);
`endif
        @(negedge clk);
        reset = 1'b0;

        // score saturation on the two-digit instance
        @(negedge clk);
        s2_start = 1'b1;
        @(posedge clk);
        #1;
        chk("s2_launch.state", 32'(s2_state), 32'd1);
        chk("s2_launch.score", 32'(s2_score), 32'h00);
        for (int unsigned k = 1; k <= 101; k++) begin
            @(negedge clk);
            s2_start = 1'b0;
            s2_hit   = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("s2_hit%0d.score", k), 32'(s2_score),
                32'(to_bcd2((k > 99) ? 99 : k)));
        end
        @(negedge clk);
        s2_hit = 1'b0;
        @(posedge clk);
        #1;
        chk("s2_final.state", 32'(s2_state), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
